// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pwm_pkg                                                   |
// | Brief    : Shared types and default widths for the PWM output slice. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package pwm_pkg;

  localparam int PWM_WIDTH      = 8;
  localparam int PWM_DEAD_WIDTH = 4;

  // Channel drive states; only HI_ON and LO_ON drive a pad.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DEAD_TO_LO = 3'd1,
    LO_ON      = 3'd2,
    DEAD_TO_HI = 3'd3,
    HI_ON      = 3'd4
  } pwm_state_e;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_deadtime.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pwm_deadtime                                              |
// | Brief    : Dead-time insertion FSM turning the raw compare into a    |
// |            non-overlapping high/low drive pair.                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DEAD_WIDTH = PWM_DEAD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  raw,
  input  logic                  enable_i,
  input  logic [DEAD_WIDTH-1:0] dead_i,
  output logic                  pwm_hi_o,
  output logic                  pwm_lo_o
);

  pwm_state_e            r_state;
  logic [DEAD_WIDTH-1:0] r_dcnt;
  logic                  r_from_idle;

  pwm_state_e            w_next;
  logic                  w_load;
  logic                  w_dec;
  logic                  w_from_idle_nxt;
  logic                  w_dead_zero;

  // A zero dead time skips the DEAD states entirely.
  assign w_dead_zero = (dead_i == '0);

  // Next-state decision; dcnt is loaded on DEAD entry and counts clocks down.
  always_comb begin
    w_next          = r_state;
    w_load          = 1'b0;
    w_dec           = 1'b0;
    w_from_idle_nxt = r_from_idle;
    if (!enable_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_next          = w_dead_zero ? LO_ON : DEAD_TO_LO;
          w_load          = 1'b1;
          w_from_idle_nxt = 1'b1;
        end
        LO_ON: begin
          if (raw) begin
            w_next = w_dead_zero ? HI_ON : DEAD_TO_HI;
            w_load = 1'b1;
          end
        end
        HI_ON: begin
          if (!raw) begin
            w_next          = w_dead_zero ? LO_ON : DEAD_TO_LO;
            w_load          = 1'b1;
            w_from_idle_nxt = 1'b0;
          end
        end
        DEAD_TO_HI: begin
          // A high pulse shorter than the dead time is swallowed.
          if (!raw)                 w_next = LO_ON;
          else if (r_dcnt == '0)    w_next = HI_ON;
          else                      w_dec  = 1'b1;
        end
        DEAD_TO_LO: begin
          // Start-up gap out of IDLE always completes before reacting to raw.
          if (raw && !r_from_idle) begin
            w_next = w_dead_zero ? HI_ON : DEAD_TO_HI;
            w_load = 1'b1;
          end else if (r_dcnt == '0) begin
            w_next = LO_ON;
          end else begin
            w_dec = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // State, dead counter and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dcnt      <= '0;
      r_from_idle <= 1'b0;
      pwm_hi_o    <= 1'b0;
      pwm_lo_o    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_from_idle <= w_from_idle_nxt;
      if (w_load)     r_dcnt <= dead_i - 1'b1;
      else if (w_dec) r_dcnt <= r_dcnt - 1'b1;
      pwm_hi_o    <= (w_next == HI_ON);
      pwm_lo_o    <= (w_next == LO_ON);
    end
  end

endmodule : pwm_deadtime
`default_nettype wire

// File: rtl/pwm_output.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pwm_output                                                |
// | Brief    : One PWM channel: double-buffered duty, period-start       |
// |            detect, compare and dead-time protected drive pair.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pwm_output
  import pwm_pkg::*;
#(
  parameter int WIDTH      = PWM_WIDTH,
  parameter int DEAD_WIDTH = PWM_DEAD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      count_i,
  input  logic [WIDTH-1:0]      duty_i,
  input  logic                  duty_valid_i,
  output logic                  duty_ready_o,
  input  logic [DEAD_WIDTH-1:0] dead_i,
  input  logic                  enable_i,
  output logic                  pwm_hi_o,
  output logic                  pwm_lo_o,
  output logic                  period_start_o
);

  logic [WIDTH-1:0] r_count_q;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_duty_active;
  logic             r_pending_full;

  logic             w_period_start;
  logic             w_accept;
  logic             w_raw;

  // Wrap is a fall to zero; count_q resets to zero so reset never fakes one.
  assign w_period_start = (count_i == '0) && (r_count_q != '0);
  assign period_start_o = w_period_start;
  assign duty_ready_o   = !r_pending_full;
  assign w_accept       = duty_valid_i && !r_pending_full;
  assign w_raw          = (count_i < r_duty_active);

  // Duty double buffer: the active threshold only moves at a period start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count_q      <= '0;
      r_pending      <= '0;
      r_duty_active  <= '0;
      r_pending_full <= 1'b0;
    end else begin
      r_count_q <= count_i;
      if (w_period_start && r_pending_full) begin
        r_duty_active  <= r_pending;
        r_pending_full <= 1'b0;
      end
      // Full buffer blocks accept, so this never collides with the transfer.
      if (w_accept) begin
        r_pending      <= duty_i;
        r_pending_full <= 1'b1;
      end
    end
  end

  pwm_deadtime #(
    .DEAD_WIDTH (DEAD_WIDTH)
  ) u_deadtime (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (w_raw),
    .enable_i (enable_i),
    .dead_i   (dead_i),
    .pwm_hi_o (pwm_hi_o),
    .pwm_lo_o (pwm_lo_o)
  );

endmodule : pwm_output
`default_nettype wire
